// File: rtl/branch_checkpoint_stack.sv
// Branch checkpoint stack: snapshots the speculative map table per in-flight branch,
// keeps snapshot ready bits current from the CDB, and restores/squashes on a mispredict.
module branch_checkpoint_stack #(
    parameter int unsigned NUM_CKPT     = 4,
    parameter int unsigned NUM_GEN_REG  = 8,
    parameter int unsigned NUM_PHYS_REG = 64,
    localparam int unsigned CKPT_W      = $clog2(NUM_CKPT),
    localparam int unsigned IDX_W       = $clog2(NUM_PHYS_REG),
    localparam int unsigned PHYS_W      = IDX_W + 1,
    localparam int unsigned CNT_W       = CKPT_W + 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 dispatch_en,
    input  logic [NUM_GEN_REG-1:0][PHYS_W-1:0]   map_table_in,
    output logic                                 dispatch_ack,
    output logic [CKPT_W-1:0]                    dispatch_id,
    input  logic                                 resolve_en,
    input  logic [CKPT_W-1:0]                    resolve_id,
    input  logic                                 resolve_correct,
    input  logic                                 CDB_en,
    input  logic [PHYS_W-1:0]                    CDB_tag_in,
    output logic                                 branch_incorrect,
    output logic [NUM_GEN_REG-1:0][PHYS_W-1:0]   map_check_point,
    output logic [NUM_CKPT-1:0]                  squash_mask,
    output logic                                 full,
    output logic [CNT_W-1:0]                     count
);

    typedef logic [NUM_GEN_REG-1:0][PHYS_W-1:0] map_t;

    localparam logic [PHYS_W-1:0] READY_BIT = {1'b1, {IDX_W{1'b0}}};

    // A matching row becomes the broadcast index with its ready bit forced on.
    function automatic map_t cdb_bypass(input map_t m, input logic en, input logic [PHYS_W-1:0] tag);
        map_t r;
        r = m;
        for (int g = 0; g < NUM_GEN_REG; g++) begin
            if (en && (m[g][IDX_W-1:0] == tag[IDX_W-1:0])) begin
                r[g] = tag | READY_BIT;
            end
        end
        return r;
    endfunction

    logic [NUM_CKPT-1:0] valid_q, valid_d;
    logic [CKPT_W-1:0]   tail_q, tail_d;
    map_t                ckpt_q [NUM_CKPT];
    map_t                ckpt_d [NUM_CKPT];

    logic                valid_resolve;
    logic                mispredict;
    logic [CKPT_W-1:0]   span;

    // Resolve decode, squash range and combinational outputs.
    always_comb begin
        valid_resolve    = resolve_en & valid_q[resolve_id];
        mispredict       = valid_resolve & ~resolve_correct;
        full             = valid_q[tail_q];
        span             = CKPT_W'(tail_q - resolve_id);
        squash_mask      = '0;
        // span==0 with a live resolve_id means the ring is full: squash everything.
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (mispredict && valid_q[i] &&
                ((span == '0) || (CKPT_W'(CKPT_W'(i) - resolve_id) < span))) begin
                squash_mask[i] = 1'b1;
            end
        end
        branch_incorrect = mispredict;
        map_check_point  = cdb_bypass(ckpt_q[resolve_id], CDB_en, CDB_tag_in);
        dispatch_ack     = dispatch_en & ~full & ~mispredict;
        dispatch_id      = tail_q;
        count            = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            count = count + CNT_W'(valid_q[i]);
        end
    end

    // Next-state: CDB wakeup on all slots, then resolve, then allocation at tail.
    always_comb begin
        valid_d = valid_q;
        tail_d  = tail_q;
        for (int s = 0; s < NUM_CKPT; s++) begin
            ckpt_d[s] = cdb_bypass(ckpt_q[s], CDB_en, CDB_tag_in);
        end
        if (valid_resolve) begin
            if (resolve_correct) begin
                valid_d[resolve_id] = 1'b0;
            end else begin
                valid_d = valid_q & ~squash_mask;
                tail_d  = resolve_id;
            end
        end
        if (dispatch_ack) begin
            ckpt_d[tail_q]  = cdb_bypass(map_table_in, CDB_en, CDB_tag_in);
            valid_d[tail_q] = 1'b1;
            tail_d          = CKPT_W'(tail_q + CKPT_W'(1));
        end
    end

    // Reset image matches the map table: row g holds tag g, ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            tail_q  <= '0;
            for (int s = 0; s < NUM_CKPT; s++) begin
                for (int g = 0; g < NUM_GEN_REG; g++) begin
                    ckpt_q[s][g] <= {1'b1, IDX_W'(g)};
                end
            end
        end else begin
            valid_q <= valid_d;
            tail_q  <= tail_d;
            for (int s = 0; s < NUM_CKPT; s++) begin
                ckpt_q[s] <= ckpt_d[s];
            end
        end
    end

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// Randomized and directed bench for branch_checkpoint_stack against a ring-buffer reference model.
module tb_branch_checkpoint_stack;

    typedef logic [7:0][6:0] map_t;

    logic       clock, reset;
    logic       dispatch_en;
    map_t       map_table_in;
    logic       dispatch_ack;
    logic [1:0] dispatch_id;
    logic       resolve_en;
    logic [1:0] resolve_id;
    logic       resolve_correct;
    logic       CDB_en;
    logic [6:0] CDB_tag_in;
    logic       branch_incorrect;
    map_t       map_check_point;
    logic [3:0] squash_mask;
    logic       full;
    logic [2:0] count;

    branch_checkpoint_stack #(
        .NUM_CKPT(4), .NUM_GEN_REG(8), .NUM_PHYS_REG(64)
    ) dut (
        .clock(clock), .reset(reset),
        .dispatch_en(dispatch_en), .map_table_in(map_table_in),
        .dispatch_ack(dispatch_ack), .dispatch_id(dispatch_id),
        .resolve_en(resolve_en), .resolve_id(resolve_id), .resolve_correct(resolve_correct),
        .CDB_en(CDB_en), .CDB_tag_in(CDB_tag_in),
        .branch_incorrect(branch_incorrect), .map_check_point(map_check_point),
        .squash_mask(squash_mask), .full(full), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    bit         m_valid [4];
    int         m_tail;
    logic [6:0] m_ckpt [4][8];

    logic        obs_ack, obs_bi;
    logic [1:0]  obs_id;
    logic [3:0]  obs_mask;
    logic [55:0] obs_mcp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            m_valid[s] = 1'b0;
            for (int r = 0; r < 8; r++) m_ckpt[s][r] = 7'h40 | 7'(r);
        end
        m_tail = 0;
    endfunction

    function automatic logic [6:0] fix(input logic [6:0] row, input logic cen, input logic [6:0] ctag);
        if (cen && row[5:0] == ctag[5:0]) return row | 7'h40;
        return row;
    endfunction

    function automatic map_t rand_map();
        map_t m;
        for (int r = 0; r < 8; r++) m[r] = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 15))};
        return m;
    endfunction

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic den, input map_t mi, input logic ren, input int rid,
                        input logic rc, input logic cen, input logic [6:0] ctag);
        logic [3:0]  e_mask;
        logic [55:0] e_mcp;
        logic        e_vr, e_mis, e_ack, e_full;
        int          e_cnt, k;
        dispatch_en = den; map_table_in = mi; resolve_en = ren; resolve_id = 2'(rid);
        resolve_correct = rc; CDB_en = cen; CDB_tag_in = ctag;
        @(negedge clock);
        e_full = m_valid[m_tail];
        e_cnt  = 0;
        for (int s = 0; s < 4; s++) e_cnt += int'(m_valid[s]);
        e_vr   = ren && m_valid[rid];
        e_mis  = e_vr && !rc;
        e_mask = '0;
        if (e_mis) begin
            k = rid;
            do begin
                if (m_valid[k]) e_mask[k] = 1'b1;
                k = (k + 1) % 4;
            end while (k != m_tail);
        end
        e_ack = den && !e_full && !e_mis;
        for (int r = 0; r < 8; r++) e_mcp[r*7 +: 7] = fix(m_ckpt[rid][r], cen, ctag);
        check("full", 64'(full), 64'(e_full));
        check("count", 64'(count), 64'(e_cnt));
        check("dispatch_ack", 64'(dispatch_ack), 64'(e_ack));
        check("branch_incorrect", 64'(branch_incorrect), 64'(e_mis));
        check("squash_mask", 64'(squash_mask), 64'(e_mask));
        if (e_ack) check("dispatch_id", 64'(dispatch_id), 64'(m_tail));
        if (e_mis) check("map_check_point", 64'(map_check_point), 64'(e_mcp));
        obs_ack = dispatch_ack; obs_bi = branch_incorrect; obs_id = dispatch_id;
        obs_mask = squash_mask; obs_mcp = map_check_point;
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 8; r++) m_ckpt[s][r] = fix(m_ckpt[s][r], cen, ctag);
        if (e_vr) begin
            if (rc) m_valid[rid] = 1'b0;
            else begin
                for (int s = 0; s < 4; s++) if (e_mask[s]) m_valid[s] = 1'b0;
                m_tail = rid;
            end
        end
        if (e_ack) begin
            for (int r = 0; r < 8; r++) m_ckpt[m_tail][r] = fix(mi[r], cen, ctag);
            m_valid[m_tail] = 1'b1;
            m_tail = (m_tail + 1) % 4;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic mid_reset();
        dispatch_en = 1'b0; resolve_en = 1'b0; CDB_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_full", 64'(full), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_ack", 64'(dispatch_ack), 64'(0));
        check("rst_bi", 64'(branch_incorrect), 64'(0));
        check("rst_mask", 64'(squash_mask), 64'(0));
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    map_t m5, z;

    initial begin
        reset = 1'b1; dispatch_en = 0; resolve_en = 0; resolve_id = 0; resolve_correct = 0;
        CDB_en = 0; CDB_tag_in = 0; map_table_in = '0;
        for (int r = 0; r < 8; r++) m5[r] = 7'h40 | 7'(r);
        m5[5] = 7'h0A;
        z = m5;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;

        step(0, z, 0, 0, 0, 0, 0);
        // Reset mid-traffic with two live checkpoints.
        step(1, rand_map(), 0, 0, 0, 0, 0);
        step(1, rand_map(), 0, 0, 0, 0, 0);
        mid_reset();
        step(1, rand_map(), 0, 0, 0, 0, 0);
        check("post_reset_id", 64'(obs_id), 64'(0));
        mid_reset();

        // Fill all four slots, then a refused fifth dispatch.
        for (int i = 0; i < 4; i++) begin
            step(1, rand_map(), 0, 0, 0, 0, 0);
            check("fill_id", 64'(obs_id), 64'(i));
        end
        step(1, rand_map(), 0, 0, 0, 0, 0);
        check("fifth_ack", 64'(obs_ack), 64'(0));
        check("full_count", 64'(count), 64'(4));

        // Mispredict ID 1 with tail wrapped to 0.
        step(0, z, 1, 1, 0, 0, 0);
        check("mp1_bi", 64'(obs_bi), 64'(1));
        check("mp1_mask", 64'(obs_mask), 64'(4'b1110));
        step(1, rand_map(), 0, 0, 0, 0, 0);
        check("mp1_next_id", 64'(obs_id), 64'(1));
        step(1, rand_map(), 0, 0, 0, 0, 0);
        step(1, rand_map(), 0, 0, 0, 0, 0);

        // Mispredict ID 2 racing a dispatch.
        step(1, rand_map(), 1, 2, 0, 0, 0);
        check("mp2_ack", 64'(obs_ack), 64'(0));
        check("mp2_mask", 64'(obs_mask), 64'(4'b1100));
        step(1, rand_map(), 0, 0, 0, 0, 0);
        step(1, rand_map(), 0, 0, 0, 0, 0);

        // Correct resolve of ID 0 while full, with dispatch.
        step(1, rand_map(), 1, 0, 1, 0, 0);
        step(1, rand_map(), 0, 0, 0, 0, 0);
        check("reuse_id0", 64'(obs_id), 64'(0));

        // Resolve of a non-live ID.
        mid_reset();
        step(0, z, 1, 2, 0, 0, 0);
        check("dead_bi", 64'(obs_bi), 64'(0));
        check("dead_mask", 64'(obs_mask), 64'(0));

        // CDB wakeup of a snapshot row: later, at dispatch, at mispredict.
        step(1, m5, 0, 0, 0, 0, 0);
        step(0, z, 0, 0, 0, 1, 7'h4A);
        step(0, z, 1, 0, 0, 0, 0);
        check("cdb_later", 64'(obs_mcp[41:35]), 64'(7'h4A));
        step(1, m5, 0, 0, 0, 1, 7'h4A);
        step(0, z, 1, 0, 0, 0, 0);
        check("cdb_dispatch", 64'(obs_mcp[41:35]), 64'(7'h4A));
        step(1, m5, 0, 0, 0, 0, 0);
        step(0, z, 1, 0, 0, 1, 7'h4A);
        check("cdb_restore", 64'(obs_mcp[41:35]), 64'(7'h4A));

        // Randomized traffic with occasional mid-traffic resets.
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 149) mid_reset();
            else step(1'($urandom_range(0, 1)), rand_map(),
                      1'($urandom_range(0, 9) < 4), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                      {1'($urandom_range(0, 1)), 6'($urandom_range(0, 15))});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
